// File: rtl/pe_split_pkg.sv
// Shared encodings for the partial-sum split scheduler: route select values and FSM states.
// The select encodings match the CSP split sel used elsewhere in the PE.
package pe_split_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_R1   = 2'b01;
  localparam logic [1:0] SEL_R2   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/split_out_reg.sv
// One-entry valid/ready holding register with a route tag; presents the held item on R1 or R2.
module split_out_reg
  import pe_split_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [1:0]       load_sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic             r1_ready,
  input  logic             r2_ready,
  output logic             out_vld,
  output logic             sel_ready,
  output logic             out_fire,
  output logic [1:0]       sel,
  output logic             r1_valid,
  output logic             r2_valid,
  output logic [WIDTH-1:0] r1_data,
  output logic [WIDTH-1:0] r2_data
);

  logic             vld_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      sel_q  <= SEL_NONE;
      // NOTE: the data flop is reset because the outputs must read 0 straight after reset.
      data_q <= '0;
    end else if (load) begin
      vld_q  <= 1'b1;
      sel_q  <= load_sel;
      data_q <= load_data;
    end else if (out_fire) begin
      vld_q  <= 1'b0;
    end
  end

  assign sel_ready = ((sel_q == SEL_R1) && r1_ready) || ((sel_q == SEL_R2) && r2_ready);
  assign out_vld   = vld_q;
  assign out_fire  = vld_q && sel_ready;
  assign sel       = vld_q ? sel_q : SEL_NONE;
  assign r1_valid  = vld_q && (sel_q == SEL_R1);
  assign r2_valid  = vld_q && (sel_q == SEL_R2);
  assign r1_data   = data_q;
  assign r2_data   = data_q;

endmodule

// File: rtl/pe_split_sched.sv
// Split-point scheduler: routes cfg_len-1 results per window to R1 and the last one to R2.
// Optional SPLIT_SCHED_PERF_EN enables the saturating backpressure counter on stall_cnt.
module pe_split_sched
  import pe_split_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_windows,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             r1_valid,
  input  logic             r1_ready,
  output logic [WIDTH-1:0] r1_data,
  output logic             r2_valid,
  input  logic             r2_ready,
  output logic [WIDTH-1:0] r2_data,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  sched_state_t     state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] tap_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             zero_done_q;

  logic out_vld;
  logic sel_ready;
  logic out_fire;
  logic in_fire;
  logic at_tap_end;
  logic last_win;

  assign in_ready   = (state == RUN) && (!out_vld || sel_ready);
  assign in_fire    = in_valid && in_ready;
  assign at_tap_end = (tap_cnt == len_q - CNT_W'(1));
  assign last_win   = (win_cnt == win_q - CNT_W'(1));

  split_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (in_fire),
    .load_sel  (at_tap_end ? SEL_R2 : SEL_R1),
    .load_data (in_data),
    .r1_ready  (r1_ready),
    .r2_ready  (r2_ready),
    .out_vld   (out_vld),
    .sel_ready (sel_ready),
    .out_fire  (out_fire),
    .sel       (sel),
    .r1_valid  (r1_valid),
    .r2_valid  (r2_valid),
    .r1_data   (r1_data),
    .r2_data   (r2_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= CNT_W'(1);
      win_q       <= '0;
      tap_cnt     <= '0;
      win_cnt     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_windows != '0) begin
              state   <= RUN;
              // A zero length behaves as one result per window, i.e. everything goes to R2.
              len_q   <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
              win_q   <= cfg_windows;
              tap_cnt <= '0;
              win_cnt <= '0;
            end else begin
              zero_done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            if (at_tap_end) begin
              tap_cnt <= '0;
              if (win_cnt != win_q) win_cnt <= win_cnt + CNT_W'(1);
              if (last_win) state <= DRAIN;
            end else begin
              tap_cnt <= tap_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  // The final R2 handshake is combinational on r2_ready, so done is reported in that same cycle.
  assign done = zero_done_q || ((state == DRAIN) && out_fire);

`ifdef SPLIT_SCHED_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state == IDLE) && start) begin
      stall_q <= '0;
    end else if (out_vld && !sel_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_split_sched.sv
// Directed self-checking bench for pe_split_sched: routing, backpressure, degenerate config, reset.
module tb_pe_split_sched;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_windows = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             r1_valid;
  logic             r1_ready = 1'b1;
  logic [WIDTH-1:0] r1_data;
  logic             r2_valid;
  logic             r2_ready = 1'b1;
  logic [WIDTH-1:0] r2_data;
  logic [1:0]       sel;
  logic             busy;
  logic             done;
  logic [15:0]      stall_cnt;

  pe_split_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_len     (cfg_len),
    .cfg_windows (cfg_windows),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .r1_valid    (r1_valid),
    .r1_ready    (r1_ready),
    .r1_data     (r1_data),
    .r2_valid    (r2_valid),
    .r2_ready    (r2_ready),
    .r2_data     (r2_data),
    .sel         (sel),
    .busy        (busy),
    .done        (done),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [WIDTH-1:0] r1_q[$];
  logic [WIDTH-1:0] r2_q[$];
  int               done_cnt = 0;
  logic [WIDTH-1:0] done_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Handshakes observed mid-cycle complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r1_valid && r1_ready) r1_q.push_back(r1_data);
      if (r2_valid && r2_ready) r2_q.push_back(r2_data);
      if (done) begin
        done_cnt++;
        done_data = r2_data;
      end
    end
  end

  task automatic clear_obs();
    r1_q.delete();
    r2_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_job(input int len, input int win);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_len = len[CNT_W-1:0];
    cfg_windows = win[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int base, output int cycles);
    bit ok;
    int guard;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data = WIDTH'(base + i);
      ok = 1'b0;
      guard = 0;
      while (!ok && guard < 50) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        cycles++;
        guard++;
      end
      if (!ok) check("feed_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cnt);
    int guard;
    guard = 0;
    while (done_cnt < exp_cnt && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, done_cnt, exp_cnt);
  endtask

  task automatic check_q(input string tag, input logic [WIDTH-1:0] got[$],
                         input logic [WIDTH-1:0] exp[$]);
    check({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_r1_valid"}, r1_valid, 0);
    check({tag, "_r2_valid"}, r2_valid, 0);
    check({tag, "_r1_data"}, r1_data, 0);
    check({tag, "_r2_data"}, r2_data, 0);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    int cyc;
    int dc;
    logic [WIDTH-1:0] e1[$];
    logic [WIDTH-1:0] e2[$];

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic routing: len 3, 2 windows, inputs 10..15.
    clear_obs();
    start_job(3, 2);
    check("t1_busy", busy, 1);
    feed(6, 10, cyc);
    check("t1_cycles", cyc, 6);
    wait_done("t1_done_cnt", 1);
    check("t1_done_data", done_data, 15);
    check("t1_busy_end", busy, 0);
    e1 = '{8'd10, 8'd11, 8'd13, 8'd14};
    e2 = '{8'd12, 8'd15};
    check_q("t1_r1", r1_q, e1);
    check_q("t1_r2", r2_q, e2);

    // Backpressure: R2 stalls 4 cycles while 22 is pending.
    clear_obs();
    start_job(3, 2);
    r2_ready = 1'b0;
    feed(3, 20, cyc);
    in_valid = 1'b1;
    in_data = 8'd23;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_in_ready_%0d", i), in_ready, 0);
      check($sformatf("t2_r2_valid_%0d", i), r2_valid, 1);
      check($sformatf("t2_r2_data_%0d", i), r2_data, 22);
      @(posedge clk); #1;
    end
    r2_ready = 1'b1;
    feed(3, 23, cyc);
    wait_done("t2_done_cnt", 1);
`ifdef SPLIT_SCHED_PERF_EN
    check("t2_stall", stall_cnt, 4);
`else
    check("t2_stall", stall_cnt, 0);
`endif
    e1 = '{8'd20, 8'd21, 8'd23, 8'd24};
    e2 = '{8'd22, 8'd25};
    check_q("t2_r1", r1_q, e1);
    check_q("t2_r2", r2_q, e2);

    // cfg_len 0 behaves as 1: everything to R2.
    clear_obs();
    start_job(0, 3);
    feed(3, 7, cyc);
    wait_done("t3_done_cnt", 1);
    check("t3_done_data", done_data, 9);
    check("t3_r1_n", r1_q.size(), 0);
    e2 = '{8'd7, 8'd8, 8'd9};
    check_q("t3_r2", r2_q, e2);

    // cfg_windows 0: done one cycle after start, never busy.
    clear_obs();
    start_job(4, 0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    @(negedge clk);
    check("t4_done_low", done, 0);
    check("t4_busy_low", busy, 0);

    // Start while busy is ignored.
    clear_obs();
    start_job(3, 2);
    feed(2, 30, cyc);
    start = 1'b1;
    cfg_len = 8'd5;
    cfg_windows = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t5_busy", busy, 1);
    feed(4, 32, cyc);
    wait_done("t5_done_cnt", 1);
    e1 = '{8'd30, 8'd31, 8'd33, 8'd34};
    e2 = '{8'd32, 8'd35};
    check_q("t5_r1", r1_q, e1);
    check_q("t5_r2", r2_q, e2);

    // Reset mid-job, then a full clean job.
    clear_obs();
    start_job(3, 2);
    feed(2, 40, cyc);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt, dc);
    rst_n = 1'b1;
    clear_obs();
    start_job(3, 2);
    feed(6, 50, cyc);
    check("t6_cycles", cyc, 6);
    wait_done("t6_done_cnt", 1);
    check("t6_done_data", done_data, 55);
    e1 = '{8'd50, 8'd51, 8'd53, 8'd54};
    e2 = '{8'd52, 8'd55};
    check_q("t6_r1", r1_q, e1);
    check_q("t6_r2", r2_q, e2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
